// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC packet framer.
// Holds the FSM state enum, the default header/trailer tags, the header and
// trailer field widths and packed layouts, plus small word-building helpers.
package adc_frame_pkg;

  localparam int unsigned TAG_W  = 16;
  localparam int unsigned PAD_W  = 5;
  localparam int unsigned CHAN_W = 3;
  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HDR_W  = TAG_W + PAD_W + CHAN_W + SEQ_W;

  localparam logic [TAG_W-1:0] MAGIC_DEFAULT     = 16'hADC0;
  localparam logic [TAG_W-1:0] TRAIL_TAG_DEFAULT = 16'hE0F0;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    HDR0,
    HDR1,
    HOLD,
    STREAM,
    TRAIL,
    WAITTX
  } frame_state_e;

  // Header word 0 layout (MSB first).
  typedef struct packed {
    logic [TAG_W-1:0]  magic;
    logic [PAD_W-1:0]  pad;
    logic [CHAN_W-1:0] chan;
    logic [SEQ_W-1:0]  seq;
  } hdr0_t;

  // Trailer word layout (MSB first).
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] count;
  } trail_t;

  function automatic logic [HDR_W-1:0] hdr0_word(input logic [TAG_W-1:0]  magic,
                                                 input logic [CHAN_W-1:0] chan,
                                                 input logic [SEQ_W-1:0]  seq);
    hdr0_t h;
    h.magic = magic;
    h.pad   = '0;
    h.chan  = chan;
    h.seq   = seq;
    return h;
  endfunction

  function automatic logic [HDR_W-1:0] trail_word(input logic [TAG_W-1:0] tag,
                                                  input logic [CNT_W-1:0] count);
    trail_t t;
    t.tag   = tag;
    t.count = count;
    return t;
  endfunction

  // Beat counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_packet_framer_if.sv
// Bus bundle between the FIFO read controller, the framer and the downstream
// AXI-Stream consumer.
//   s_*      : controller -> framer (header request, channel, data beats)
//   s_tready : framer -> controller
//   m_*      : framer -> downstream stream, m_tready back
//   tx_done  : framer -> controller, trailer has left the block
// modport master : the framer's view (it masters the m_* stream)
// modport slave  : the environment's view (controller + downstream sink)
interface adc_packet_framer_if
  import adc_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) ();

  logic              s_hdr_valid;
  logic [CHAN_W-1:0] s_addr;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              tx_done;

  modport master (
    input  s_hdr_valid, s_addr, s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, tx_done
  );

  modport slave (
    output s_hdr_valid, s_addr, s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, tx_done
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry output skid buffer with a registered input ready.
// Entry 0 is always the head, so out_data/out_valid come straight from flops.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   in_valid/in_data : push request and payload
//   in_ready         : registered, high while fewer than two entries are held
//   in_ready_nxt_c   : value in_ready takes at the next edge (combinational)
//   out_valid/out_data/out_ready : head of buffer, popped on handshake
module axis_skid_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         in_ready_nxt_c,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic         v0_q, v0_d, v1_q, v1_d;
  logic         rdy_q;
  logic         push_c, pop_c;

  // Pop shifts entry 1 into the head, then a push fills the first free slot.
  always_comb begin
    d0_d   = d0_q;
    d1_d   = d1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    push_c = in_valid & rdy_q;
    pop_c  = v0_q & out_ready;
    if (pop_c) begin
      d0_d = d1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (push_c) begin
      if (!v0_d) begin
        d0_d = in_data;
        v0_d = 1'b1;
      end else begin
        d1_d = in_data;
        v1_d = 1'b1;
      end
    end
    in_ready_nxt_c = ~(v0_d & v1_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      d0_q  <= '0;
      d1_q  <= '0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      rdy_q <= in_ready_nxt_c;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = v0_q;
  assign out_data  = d0_q;

endmodule

// File: rtl/adc_packet_framer.sv
// Wraps each controller burst into a packet: header 0, header 1, data beats,
// trailer (tlast). Pulses tx_done the cycle after the trailer handshake.
// Optional build macro: FRAMER_STATS_EN adds pkt_cnt / ovr_cnt outputs.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   bus       : adc_packet_framer_if.master (s_* in, s_tready, m_* out, tx_done)
//   pkt_cnt   : trailers sent, wraps          (FRAMER_STATS_EN only)
//   ovr_cnt   : s_hdr_valid outside IDLE      (FRAMER_STATS_EN only)
module adc_packet_framer
  import adc_frame_pkg::*;
#(
  parameter int unsigned      DATA_W    = 32,
  parameter logic [TAG_W-1:0] MAGIC     = MAGIC_DEFAULT,
  parameter logic [TAG_W-1:0] TRAIL_TAG = TRAIL_TAG_DEFAULT
) (
  input logic                 clk,
  input logic                 rstn,
  adc_packet_framer_if.master bus
`ifdef FRAMER_STATS_EN
  ,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    ovr_cnt
`endif
);

  localparam int unsigned SKID_W = DATA_W + 1;

  frame_state_e      state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              end_q, end_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              s_tready_q, s_tready_d;
  logic              tx_done_q, tx_done_d;

  logic              push_c;
  logic [DATA_W-1:0] push_data_c;
  logic              push_last_c;
  logic              beat_c;

  logic              skid_rdy;
  logic              skid_rdy_nxt_c;
  logic              skid_valid;
  logic [SKID_W-1:0] skid_data;

`ifdef FRAMER_STATS_EN
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
`endif

  axis_skid_buf #(
    .W (SKID_W)
  ) u_skid (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (push_c),
    .in_data        ({push_last_c, push_data_c}),
    .in_ready       (skid_rdy),
    .in_ready_nxt_c (skid_rdy_nxt_c),
    .out_valid      (skid_valid),
    .out_data       (skid_data),
    .out_ready      (bus.m_tready)
  );

  // Next-state and push logic; every push state waits for skid ready.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    end_d       = end_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    tx_done_d   = 1'b0;
    push_c      = 1'b0;
    push_data_c = '0;
    push_last_c = 1'b0;
    // s_tready is only ever high in FIRST/STREAM, and then implies skid ready.
    beat_c      = bus.s_tvalid & s_tready_q;

    case (state_q)
      IDLE: begin
        if (bus.s_hdr_valid) begin
          state_d     = FIRST;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          end_d       = 1'b0;
        end
      end
      FIRST: begin
        if (beat_c) begin
          chan_d      = bus.s_addr;
          hold_d      = bus.s_tdata;
          hold_full_d = 1'b1;
          cnt_d       = CNT_W'(1);
          end_d       = bus.s_tlast;
          state_d     = HDR0;
        end else if (bus.s_tlast) begin
          // Zero-data packet: header then straight to the trailer.
          chan_d      = '0;
          hold_full_d = 1'b0;
          state_d     = HDR0;
        end
      end
      HDR0: begin
        push_c      = 1'b1;
        push_data_c = DATA_W'(hdr0_word(MAGIC, chan_q, seq_q));
        if (skid_rdy) state_d = HDR1;
      end
      HDR1: begin
        push_c      = 1'b1;
        push_data_c = '0;
        if (skid_rdy) state_d = hold_full_q ? HOLD : TRAIL;
      end
      HOLD: begin
        push_c      = 1'b1;
        push_data_c = hold_q;
        if (skid_rdy) state_d = end_q ? TRAIL : STREAM;
      end
      STREAM: begin
        if (beat_c) begin
          push_c      = 1'b1;
          push_data_c = bus.s_tdata;
          cnt_d       = cnt_sat_inc(cnt_q);
          if (bus.s_tlast) state_d = TRAIL;
        end else if (bus.s_tlast && !bus.s_tvalid) begin
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        push_c      = 1'b1;
        push_data_c = DATA_W'(trail_word(TRAIL_TAG, cnt_q));
        push_last_c = 1'b1;
        if (skid_rdy) state_d = WAITTX;
      end
      WAITTX: begin
        // Only the trailer carries tlast, so this is the trailer handshake.
        if (skid_valid && bus.m_tready && skid_data[DATA_W]) begin
          tx_done_d = 1'b1;
          seq_d     = seq_q + SEQ_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_tready_d = (state_d == FIRST) || ((state_d == STREAM) && skid_rdy_nxt_c);

`ifdef FRAMER_STATS_EN
    pkt_cnt_d = pkt_cnt_q;
    ovr_cnt_d = ovr_cnt_q;
    if (tx_done_d) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    if (bus.s_hdr_valid && (state_q != IDLE)) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      end_q       <= 1'b0;
      cnt_q       <= '0;
      seq_q       <= '0;
      s_tready_q  <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef FRAMER_STATS_EN
      pkt_cnt_q   <= '0;
      ovr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      end_q       <= end_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      s_tready_q  <= s_tready_d;
      tx_done_q   <= tx_done_d;
`ifdef FRAMER_STATS_EN
      pkt_cnt_q   <= pkt_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
`endif
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tdata  = skid_data[DATA_W-1:0];
  assign bus.m_tlast  = skid_data[DATA_W];
  assign bus.m_tvalid = skid_valid;
  assign bus.tx_done  = tx_done_q;

`ifdef FRAMER_STATS_EN
  assign pkt_cnt = pkt_cnt_q;
  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_adc_packet_framer.sv
// Bench for adc_packet_framer: a packet-level model (expected word queue built
// from the framing rules) checked on every output handshake, tx_done checked
// every cycle, plus literal expectations for selected words.
module tb_adc_packet_framer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  adc_packet_framer_if #(.DATA_W(32)) bus ();

`ifdef FRAMER_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] ovr_cnt;
`endif

  adc_packet_framer #(.DATA_W(32)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus)
`ifdef FRAMER_STATS_EN
    ,
    .pkt_cnt (pkt_cnt),
    .ovr_cnt (ovr_cnt)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic        chk_en = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;
  logic        prev_hs = 1'b0;
  logic        m_rdy;
  logic [32:0] exp_q[$];
  logic [31:0] rx_log[$];
  logic [31:0] pkt_data[$];
  logic [7:0]  model_seq = 8'h00;
  int          pkts_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at t=%0t", nm, $time);
  endtask

  task automatic lit(input string nm, input int idx, input logic [31:0] exp);
    logic [63:0] a;
    a = (idx < rx_log.size()) ? {32'h0, rx_log[idx]} : 64'hFFFF_FFFF_FFFF_FFFF;
    chk(nm, a, {32'h0, exp});
  endtask

  // Expected output words for one packet, from the framing rules.
  task automatic model_packet(input logic [2:0] chan, input int n);
    logic [15:0] cnt;
    logic [2:0]  hchan;
    cnt   = (n > 65535) ? 16'hFFFF : 16'(n);
    hchan = (n == 0) ? 3'd0 : chan;
    exp_q.push_back({1'b0, 16'hADC0, 5'b0, hchan, model_seq});
    exp_q.push_back(33'h0);
    foreach (pkt_data[k]) exp_q.push_back({1'b0, pkt_data[k]});
    exp_q.push_back({1'b1, 16'hE0F0, cnt});
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (bus.tx_done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) timeout("tx_done_wait");
    else begin
      model_seq = model_seq + 8'd1;
      pkts_done++;
    end
  endtask

  // Controller emulation: drives a beat whenever s_tready is high.
  task automatic send_packet(input logic [2:0] chan, input int ovr_at, input int abort_at);
    int n;
    int i;
    int guard;
    n = pkt_data.size();
    i = 0;
    guard = 0;
    if (abort_at < 0) model_packet(chan, n);
    bus.s_hdr_valid = 1'b1;
    @(negedge clk);
    bus.s_hdr_valid = 1'b0;
    if (n == 0) begin
      while (!bus.s_tready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) timeout("zero_pkt_ready");
      bus.s_tlast = 1'b1;
      @(negedge clk);
      bus.s_tlast = 1'b0;
    end else begin
      while (i < n) begin
        if (abort_at >= 0 && i == abort_at) break;
        bus.s_hdr_valid = 1'b0;
        if (bus.s_tready) begin
          bus.s_tvalid    = 1'b1;
          bus.s_addr      = chan;
          bus.s_tdata     = pkt_data[i];
          bus.s_tlast     = (i == n - 1);
          bus.s_hdr_valid = (i == ovr_at);
          i++;
        end else begin
          bus.s_tvalid = 1'b0;
          bus.s_tlast  = 1'b0;
        end
        @(negedge clk);
        guard++;
        if (guard > 20000) begin
          timeout("beat_feed");
          break;
        end
      end
    end
    bus.s_tvalid    = 1'b0;
    bus.s_tlast     = 1'b0;
    bus.s_hdr_valid = 1'b0;
    if (abort_at < 0) wait_done();
  endtask

  // Downstream sink + checker: sets m_tready for the coming edge, then checks
  // the word that handshakes on it; tx_done must follow a tlast handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    m_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    bus.m_tready = m_rdy;
    if (chk_en) begin
      chk("tx_done", 64'(bus.tx_done), 64'(prev_hs));
      if (bus.m_tvalid && m_rdy) begin
        rx_log.push_back(bus.m_tdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {32'h0, bus.m_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", {32'h0, bus.m_tdata}, {32'h0, e[31:0]});
          chk("m_tlast", 64'(bus.m_tlast), 64'(e[32]));
        end
      end
    end
    prev_hs = chk_en && bus.m_tvalid && m_rdy && bus.m_tlast;
  end

  initial begin
    int idx;
    int idx_ff;
    int idx_00;
    idx_ff = -1;
    idx_00 = -1;
    rstn            = 1'b0;
    bus.s_hdr_valid = 1'b0;
    bus.s_addr      = 3'd0;
    bus.s_tdata     = 32'h0;
    bus.s_tvalid    = 1'b0;
    bus.s_tlast     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(bus.s_tready), 64'(1'b0));
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'(1'b0));
    chk("rst_m_tdata",  {32'h0, bus.m_tdata}, 64'h0);
    chk("rst_m_tlast",  64'(bus.m_tlast), 64'(1'b0));
    chk("rst_tx_done",  64'(bus.tx_done), 64'(1'b0));
`ifdef FRAMER_STATS_EN
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
    chk("rst_ovr_cnt", 64'(ovr_cnt), 64'h0);
`endif
    rstn = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Three-beat packet on channel 2.
    pkt_data.delete();
    pkt_data.push_back(32'h11);
    pkt_data.push_back(32'h22);
    pkt_data.push_back(32'h33);
    idx = rx_log.size();
    send_packet(3'd2, -1, -1);
    lit("p1_hdr0",  idx + 0, 32'hADC0_0200);
    lit("p1_hdr1",  idx + 1, 32'h0000_0000);
    lit("p1_beat0", idx + 2, 32'h0000_0011);
    lit("p1_beat1", idx + 3, 32'h0000_0022);
    lit("p1_beat2", idx + 4, 32'h0000_0033);
    lit("p1_trail", idx + 5, 32'hE0F0_0003);

    // Zero-data packet, issued back-to-back on the tx_done cycle (seq 1).
    pkt_data.delete();
    idx = rx_log.size();
    send_packet(3'd6, -1, -1);
    lit("p0_hdr0",  idx + 0, 32'hADC0_0001);
    lit("p0_hdr1",  idx + 1, 32'h0000_0000);
    lit("p0_trail", idx + 2, 32'hE0F0_0000);

    // 1024-beat burst with m_tready high one cycle in three.
    rdy_mode = 1;
    pkt_data.delete();
    for (int k = 0; k < 1024; k++) pkt_data.push_back(32'h1000_0000 + 32'(k));
    idx = rx_log.size();
    send_packet(3'd7, -1, -1);
    lit("burst_hdr0",  idx + 0, 32'hADC0_0702);
    lit("burst_trail", idx + 1026, 32'hE0F0_0400);
    rdy_mode = 0;

    // 256 back-to-back one-beat packets; seq wraps 0xFF -> 0x00.
    for (int k = 0; k < 256; k++) begin
      pkt_data.delete();
      pkt_data.push_back(32'hA500_0000 + 32'(k));
      if (model_seq == 8'hFF) idx_ff = rx_log.size();
      if (model_seq == 8'h00) idx_00 = rx_log.size();
      send_packet(3'd5, -1, -1);
    end
    lit("seq_ff_hdr0", idx_ff, 32'hADC0_05FF);
    lit("seq_00_hdr0", idx_00, 32'hADC0_0500);

    // s_hdr_valid pulsed mid-stream must be ignored.
    pkt_data.delete();
    for (int k = 0; k < 8; k++) pkt_data.push_back(32'hC0DE_0000 + 32'(k));
    send_packet(3'd3, 3, -1);
    repeat (10) @(negedge clk);
    chk("ovr_no_restart_tready", 64'(bus.s_tready), 64'(1'b0));
    chk("ovr_no_restart_tvalid", 64'(bus.m_tvalid), 64'(1'b0));
`ifdef FRAMER_STATS_EN
    chk("ovr_cnt", 64'(ovr_cnt), 64'h1);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(16'(pkts_done)));
`endif

    // Reset in STREAM with a partial packet in flight.
    chk_en = 1'b0;
    @(negedge clk);
    pkt_data.delete();
    for (int k = 0; k < 50; k++) pkt_data.push_back(32'hBAD0_0000 + 32'(k));
    send_packet(3'd4, -1, 5);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_tready", 64'(bus.s_tready), 64'(1'b0));
    chk("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'(1'b0));
    chk("mid_rst_m_tdata",  {32'h0, bus.m_tdata}, 64'h0);
    chk("mid_rst_m_tlast",  64'(bus.m_tlast), 64'(1'b0));
    chk("mid_rst_tx_done",  64'(bus.tx_done), 64'(1'b0));
`ifdef FRAMER_STATS_EN
    chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
    chk("mid_rst_ovr_cnt", 64'(ovr_cnt), 64'h0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    model_seq = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_tx_done", 64'(bus.tx_done), 64'(1'b0));
    end
    chk_en = 1'b1;
    @(negedge clk);

    // Fresh packet after reset starts again at seq 0.
    pkt_data.delete();
    pkt_data.push_back(32'h0000_AAAA);
    pkt_data.push_back(32'h0000_BBBB);
    idx = rx_log.size();
    send_packet(3'd1, -1, -1);
    lit("post_rst_hdr0",  idx + 0, 32'hADC0_0100);
    lit("post_rst_trail", idx + 4, 32'hE0F0_0002);
    repeat (5) @(negedge clk);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
